// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32I pipeline: drives a req/ack data bus for loads
// and stores, stalls upstream while a bus access is pending, and owns MEM/WB.
module mem_access_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_four_i,
  input  logic [31:0] alu_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [3:0]  ld_op_i,
  input  logic        jump_i,
  input  logic        mem_wren_i,
  input  logic        is_load_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_wren_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wren_o,
  output logic        misaligned_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_signed;
  logic        w_misaligned;
  logic        w_start;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_data;
  logic [31:0] w_wb_next;

  assign w_access    = is_load_i | mem_wren_i;
  assign w_off       = alu_data_i[1:0];
  assign w_is_byte   = (ld_op_i == 4'b0000) || (ld_op_i == 4'b0100);
  assign w_is_half   = (ld_op_i == 4'b0001) || (ld_op_i == 4'b0101);
  assign w_is_signed = (ld_op_i == 4'b0000) || (ld_op_i == 4'b0001);

  // Anything that is neither byte nor half is a word access.
  assign w_misaligned = w_access &
                        ((w_is_half & w_off[0]) |
                         (!w_is_byte & !w_is_half & (w_off != 2'b00)));

  assign w_start = (r_state == S_IDLE) & w_access & !w_misaligned;
  assign stall_o = rst_i & (w_start | ((r_state == S_BUSY) & !dbus_ack_i));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_BUSY;
      S_BUSY: if (dbus_ack_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_data_i;
    if (mem_wren_i) begin
      if (w_is_byte) begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{rs2_data_i[7:0]}};
      end else if (w_is_half) begin
        w_be    = 4'b0011 << {w_off[1], 1'b0};
        w_wdata = {2{rs2_data_i[15:0]}};
      end
    end
  end

  always_comb begin
    case (w_off)
      2'd0:    w_lane_b = dbus_rdata_i[7:0];
      2'd1:    w_lane_b = dbus_rdata_i[15:8];
      2'd2:    w_lane_b = dbus_rdata_i[23:16];
      default: w_lane_b = dbus_rdata_i[31:24];
    endcase
    w_lane_h = w_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    if (w_is_byte)
      w_load_data = {{24{w_is_signed & w_lane_b[7]}}, w_lane_b};
    else if (w_is_half)
      w_load_data = {{16{w_is_signed & w_lane_h[15]}}, w_lane_h};
    else
      w_load_data = dbus_rdata_i;
  end

  assign w_wb_next = is_load_i ? w_load_data : (jump_i ? pc_four_i : alu_data_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Bus outputs are only loaded on request start, so they stay put until ack.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= 32'd0;
      dbus_be_o    <= 4'd0;
      dbus_wdata_o <= 32'd0;
    end else if (w_start) begin
      dbus_req_o   <= 1'b1;
      dbus_we_o    <= mem_wren_i;
      dbus_addr_o  <= {alu_data_i[31:2], 2'b00};
      dbus_be_o    <= w_be;
      dbus_wdata_o <= w_wdata;
    end else if ((r_state == S_BUSY) && dbus_ack_i) begin
      dbus_req_o   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_data_o    <= 32'd0;
      rd_addr_o    <= 5'd0;
      rd_wren_o    <= 1'b0;
      misaligned_o <= 1'b0;
    end else if (!stall_o) begin
      wb_data_o    <= w_wb_next;
      rd_addr_o    <= rd_addr_i;
      rd_wren_o    <= rd_wren_i & !w_misaligned;
      misaligned_o <= w_misaligned;
    end else begin
      rd_wren_o    <= 1'b0;
      misaligned_o <= 1'b0;
    end
  end

endmodule
